// File: rtl/fb_strip_arbiter.sv
// Single-port strip frame buffer arbiter: a fixed 4-slot frame gives one scan-out
// read (slot 0) and three round-robin write slots (slots 1..3) to the RT cores.
module fb_strip_arbiter #(
  parameter int PIX_W      = 16,
  parameter int H_RES      = 640,
  parameter int STRIP_ROWS = 64,
  parameter int N_WR       = 2,
  parameter int ADDR_W     = 16
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic [9:0]              DRAW_X,
  input  logic [9:0]              DRAW_Y,
  output logic [PIX_W-1:0]        PIX_OUT,
  output logic                    PIX_STROBE,
  input  logic [N_WR-1:0]         WR_VALID,
  output logic [N_WR-1:0]         WR_READY,
  input  logic [10*N_WR-1:0]      WR_X,
  input  logic [10*N_WR-1:0]      WR_Y,
  input  logic [PIX_W*N_WR-1:0]   WR_DATA,
  output logic [ADDR_W-1:0]       MEM_ADDR,
  output logic                    MEM_WE,
  output logic [PIX_W-1:0]        MEM_WDATA,
  input  logic [PIX_W-1:0]        MEM_RDATA,
  output logic [7:0]              DROP_CNT
);

  localparam int PTR_W = (N_WR > 1) ? $clog2(N_WR) : 1;

  typedef enum logic [1:0] {
    SLOT_READ = 2'd0,
    SLOT_WR1  = 2'd1,
    SLOT_WR2  = 2'd2,
    SLOT_WR3  = 2'd3
  } slot_e;

  slot_e             slot_q, slot_d;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [PIX_W-1:0]  pix_out_q, pix_out_d;
  logic              pix_strobe_q, pix_strobe_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;

  logic              gnt_found;
  logic [PTR_W-1:0]  gnt_idx;
  logic [PTR_W-1:0]  cand_idx;
  int                cand;
  logic [9:0]        wr_x;
  logic [9:0]        wr_y;
  logic [PIX_W-1:0]  wr_data;
  logic              wr_in_range;

  // Round-robin search: first valid channel starting at rr_ptr, wrapping at N_WR-1.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 0; k < N_WR; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= N_WR) cand = cand - N_WR;
      cand_idx = PTR_W'(cand);
      if (!gnt_found && WR_VALID[cand_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    wr_x    = '0;
    wr_y    = '0;
    wr_data = '0;
    for (int i = 0; i < N_WR; i++) begin
      if (gnt_idx == PTR_W'(i)) begin
        wr_x    = WR_X[10*i +: 10];
        wr_y    = WR_Y[10*i +: 10];
        wr_data = WR_DATA[PIX_W*i +: PIX_W];
      end
    end
  end

  assign wr_in_range = (int'(wr_x) < H_RES) && (int'(wr_y) < STRIP_ROWS);

  // Slot 0 is never a write slot, and reset forces slot 0, so READY/WE stay low in reset.
  always_comb begin
    slot_d       = slot_e'(slot_q + 2'd1);
    rr_ptr_d     = rr_ptr_q;
    drop_cnt_d   = drop_cnt_q;
    pix_out_d    = (slot_q == SLOT_WR1) ? MEM_RDATA : pix_out_q;
    pix_strobe_d = (slot_q == SLOT_WR1);
    WR_READY     = '0;
    MEM_WE       = 1'b0;
    MEM_ADDR     = '0;
    MEM_WDATA    = '0;
    if (slot_q == SLOT_READ) begin
      MEM_ADDR = ADDR_W'(32'(DRAW_X) + 32'(H_RES) * (32'(DRAW_Y) % 32'(STRIP_ROWS)));
    end else if (gnt_found) begin
      WR_READY[gnt_idx] = 1'b1;
      rr_ptr_d = (int'(gnt_idx) == N_WR - 1) ? '0 : gnt_idx + 1'b1;
      if (wr_in_range) begin
        MEM_WE    = 1'b1;
        MEM_ADDR  = ADDR_W'(32'(wr_x) + 32'(H_RES) * 32'(wr_y));
        MEM_WDATA = wr_data;
      end else if (drop_cnt_q != 8'hFF) begin
        drop_cnt_d = drop_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      slot_q       <= SLOT_READ;
      rr_ptr_q     <= '0;
      pix_out_q    <= '0;
      pix_strobe_q <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      slot_q       <= slot_d;
      rr_ptr_q     <= rr_ptr_d;
      pix_out_q    <= pix_out_d;
      pix_strobe_q <= pix_strobe_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign PIX_OUT    = pix_out_q;
  assign PIX_STROBE = pix_strobe_q;
  assign DROP_CNT   = drop_cnt_q;

endmodule

// File: tb/tb_fb_strip_arbiter.sv
// Self-checking bench for fb_strip_arbiter: directed phases plus random traffic,
// compared every cycle against a slot/queue level model of the arbiter.
module tb_fb_strip_arbiter;

  localparam int PIX_W      = 16;
  localparam int H_RES      = 640;
  localparam int STRIP_ROWS = 64;
  localparam int N_WR       = 2;
  localparam int ADDR_W     = 16;

  logic                  CLK = 1'b0;
  logic                  RESET_N;
  logic [9:0]            DRAW_X, DRAW_Y;
  logic [PIX_W-1:0]      PIX_OUT;
  logic                  PIX_STROBE;
  logic [N_WR-1:0]       WR_VALID, WR_READY;
  logic [10*N_WR-1:0]    WR_X, WR_Y;
  logic [PIX_W*N_WR-1:0] WR_DATA;
  logic [ADDR_W-1:0]     MEM_ADDR;
  logic                  MEM_WE;
  logic [PIX_W-1:0]      MEM_WDATA;
  logic [PIX_W-1:0]      MEM_RDATA;
  logic [7:0]            DROP_CNT;

  fb_strip_arbiter #(
    .PIX_W(PIX_W), .H_RES(H_RES), .STRIP_ROWS(STRIP_ROWS), .N_WR(N_WR), .ADDR_W(ADDR_W)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .DRAW_X(DRAW_X), .DRAW_Y(DRAW_Y),
    .PIX_OUT(PIX_OUT), .PIX_STROBE(PIX_STROBE),
    .WR_VALID(WR_VALID), .WR_READY(WR_READY), .WR_X(WR_X), .WR_Y(WR_Y), .WR_DATA(WR_DATA),
    .MEM_ADDR(MEM_ADDR), .MEM_WE(MEM_WE), .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA),
    .DROP_CNT(DROP_CNT)
  );

  always #5 CLK = ~CLK;

  // Synchronous single-port RAM with a one-shot clear and a preload port.
  logic [15:0] ram [0:65535];
  logic        ram_clear, pre_we;
  logic [15:0] pre_addr, pre_data;
  always @(posedge CLK) begin
    if (ram_clear) begin
      for (int a = 0; a < 65536; a++) ram[a] <= '0;
    end else if (pre_we) begin
      ram[pre_addr] <= pre_data;
    end else if (MEM_WE) begin
      ram[MEM_ADDR] <= MEM_WDATA;
    end
    MEM_RDATA <= ram[MEM_ADDR];
  end

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [15:0] d;
  } req_t;

  req_t q0[$], q1[$];
  req_t cur [2];
  logic [1:0] active;
  int gap_pct;
  bit rand_draw;
  int gnt_log[$];

  // Reference model state: slot position, round-robin pointer, drops, scan-out pipeline.
  logic [15:0] shadow [0:65535];
  int          m_slot, m_ptr, m_drops;
  logic [15:0] m_pix, m_rd;
  logic        m_strobe;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic req_t mkReq(input int x, input int y, input int d);
    req_t r;
    r.x = 10'(x);
    r.y = 10'(y);
    r.d = 16'(d);
    return r;
  endfunction

  function automatic int pending();
    return q0.size() + q1.size() + int'(active[0]) + int'(active[1]);
  endfunction

  task automatic modelReset();
    m_slot = 0; m_ptr = 0; m_drops = 0; m_pix = '0; m_strobe = 1'b0;
  endtask

  // Present queued requests; an active request stays unchanged until accepted.
  task automatic applyStimulus();
    for (int c = 0; c < N_WR; c++) begin
      if (!active[c] && int'($urandom_range(99)) >= gap_pct) begin
        if (c == 0 && q0.size() > 0) begin cur[0] = q0.pop_front(); active[0] = 1'b1; end
        if (c == 1 && q1.size() > 0) begin cur[1] = q1.pop_front(); active[1] = 1'b1; end
      end
    end
    if (rand_draw && m_slot == 0) begin
      DRAW_X = 10'($urandom_range(799));
      DRAW_Y = 10'($urandom_range(1023));
    end
    WR_VALID = active;
    for (int c = 0; c < N_WR; c++) begin
      WR_X[10*c +: 10]    = cur[c].x;
      WR_Y[10*c +: 10]    = cur[c].y;
      WR_DATA[16*c +: 16] = cur[c].d;
    end
  endtask

  task automatic stepCycle();
    int g, wx, wy, ra, c;
    logic in_rng;
    @(negedge CLK);
    checkOutput("pix_out", 32'(PIX_OUT), 32'(m_pix));
    checkOutput("pix_strobe", 32'(PIX_STROBE), 32'(m_strobe));
    checkOutput("drop_cnt", 32'(DROP_CNT), 32'(m_drops));
    g = -1; wx = 0; wy = 0; in_rng = 1'b0;
    ra = (int'(DRAW_X) + H_RES * (int'(DRAW_Y) % STRIP_ROWS)) % 65536;
    if (m_slot == 0) begin
      checkOutput("ready_rd", 32'(WR_READY), 32'd0);
      checkOutput("we_rd", 32'(MEM_WE), 32'd0);
      checkOutput("addr_rd", 32'(MEM_ADDR), 32'(ra));
      checkOutput("wdata_rd", 32'(MEM_WDATA), 32'd0);
    end else begin
      for (int k = 0; k < N_WR; k++) begin
        c = (m_ptr + k) % N_WR;
        if (g < 0 && active[c]) g = c;
      end
      if (g < 0) begin
        checkOutput("ready_idle", 32'(WR_READY), 32'd0);
        checkOutput("we_idle", 32'(MEM_WE), 32'd0);
        checkOutput("addr_idle", 32'(MEM_ADDR), 32'd0);
      end else begin
        wx = int'(cur[g].x);
        wy = int'(cur[g].y);
        in_rng = (wx < H_RES) && (wy < STRIP_ROWS);
        checkOutput("ready_gnt", 32'(WR_READY), 32'(1 << g));
        checkOutput("we_gnt", 32'(MEM_WE), 32'(in_rng));
        if (in_rng) begin
          checkOutput("addr_wr", 32'(MEM_ADDR), 32'(wx + H_RES * wy));
          checkOutput("wdata_wr", 32'(MEM_WDATA), 32'(cur[g].d));
        end
      end
    end
    @(posedge CLK);
    if (m_slot == 0) m_rd = shadow[ra];
    if (g >= 0) begin
      if (in_rng) shadow[wx + H_RES * wy] = cur[g].d;
      else if (m_drops < 255) m_drops++;
      m_ptr = (g + 1) % N_WR;
      active[g] = 1'b0;
      gnt_log.push_back(g);
    end
    m_strobe = (m_slot == 1);
    if (m_slot == 1) m_pix = m_rd;
    m_slot = (m_slot + 1) % 4;
    #1;
    applyStimulus();
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (pending() > 0 && n < budget) begin
      stepCycle();
      n++;
    end
    checkOutput(tag, 32'(pending()), 32'd0);
  endtask

  initial begin
    int viol, bad;
    RESET_N = 1'b0;
    DRAW_X = '0; DRAW_Y = '0;
    WR_VALID = '0; WR_X = '0; WR_Y = '0; WR_DATA = '0;
    active = '0; gap_pct = 0; rand_draw = 1'b0;
    cur[0] = '0; cur[1] = '0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0; ram_clear = 1'b1;
    for (int a = 0; a < 65536; a++) shadow[a] = '0;
    modelReset();

    @(posedge CLK); #1;
    ram_clear = 1'b0;
    pre_we = 1'b1; pre_addr = 16'd641; pre_data = 16'hABCD;
    shadow[641] = 16'hABCD;
    @(posedge CLK); #1;
    pre_we = 1'b0;
    DRAW_X = 10'd1; DRAW_Y = 10'd65;
    #2 RESET_N = 1'b1;
    modelReset();
    $display("[TB] scan-out from preloaded address 641");
    for (int i = 0; i < 8; i++) stepCycle();
    checkOutput("scan_addr", 32'(MEM_ADDR), 32'd641);
    checkOutput("scan_pix", 32'(PIX_OUT), 32'hABCD);

    $display("[TB] out-of-range writes on channel 1");
    q1.push_back(mkReq(640, 5, 16'h1234));
    q1.push_back(mkReq(3, 64, 16'h5678));
    applyStimulus();
    drain("oor_drain", 40);
    checkOutput("oor_drop2", 32'(DROP_CNT), 32'd2);

    $display("[TB] asynchronous reset in a write slot");
    while (m_slot != 2) stepCycle();
    q0.push_back(mkReq(10, 2, 16'h1111));
    applyStimulus();
    #1 RESET_N = 1'b0;
    #1;
    checkOutput("rst_we", 32'(MEM_WE), 32'd0);
    checkOutput("rst_ready", 32'(WR_READY), 32'd0);
    checkOutput("rst_pix", 32'(PIX_OUT), 32'd0);
    checkOutput("rst_strobe", 32'(PIX_STROBE), 32'd0);
    checkOutput("rst_drop", 32'(DROP_CNT), 32'd0);
    RESET_N = 1'b1;
    modelReset();
    stepCycle();
    checkOutput("rst_first_wslot", 32'(WR_READY), 32'd1);

    $display("[TB] single channel streaming");
    for (int i = 0; i < 6; i++) q0.push_back(mkReq(100 + i, 7, 16'hC000 + i));
    applyStimulus();
    drain("stream_drain", 20);

    $display("[TB] round-robin between two channels");
    while (m_slot != 0) stepCycle();
    gnt_log.delete();
    for (int i = 0; i < 6; i++) begin
      q0.push_back(mkReq(200 + i, 9, 16'hA000 + i));
      q1.push_back(mkReq(300 + i, 9, 16'hB000 + i));
    end
    applyStimulus();
    for (int i = 0; i < 16; i++) stepCycle();
    checkOutput("rr_drain", 32'(pending()), 32'd0);
    checkOutput("rr_count", 32'(gnt_log.size()), 32'd12);
    viol = 0;
    for (int i = 1; i < gnt_log.size(); i++) if (gnt_log[i] == gnt_log[i-1]) viol++;
    checkOutput("rr_alternate", 32'(viol), 32'd0);

    $display("[TB] drop counter saturation");
    for (int i = 0; i < 300; i++) begin
      if (i % 2 == 0) q0.push_back(mkReq(640 + (i % 300), 1, i));
      else q1.push_back(mkReq(5, 64 + (i % 200), i));
    end
    applyStimulus();
    drain("sat_drain", 1000);
    checkOutput("sat_drop", 32'(DROP_CNT), 32'd255);

    $display("[TB] idle then channel 1 request");
    for (int i = 0; i < 8; i++) stepCycle();
    while (m_slot != 0) stepCycle();
    q1.push_back(mkReq(20, 20, 16'h2020));
    applyStimulus();
    stepCycle();
    checkOutput("idle_ch1_ready", 32'(WR_READY), 32'd2);
    drain("idle_drain", 8);

    $display("[TB] randomized traffic");
    #1 RESET_N = 1'b0;
    #1 RESET_N = 1'b1;
    modelReset();
    gap_pct = 30;
    rand_draw = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(99) < 60) begin
        req_t r;
        r = mkReq(int'($urandom_range(700)), int'($urandom_range(70)), int'($urandom_range(65535)));
        if ($urandom_range(1) == 0) begin
          if (q0.size() < 4) q0.push_back(r);
        end else begin
          if (q1.size() < 4) q1.push_back(r);
        end
      end
      stepCycle();
    end
    gap_pct = 0;
    drain("rand_drain", 200);

    bad = 0;
    for (int a = 0; a < 65536; a++) if (ram[a] !== shadow[a]) bad++;
    checkOutput("ram_contents", 32'(bad), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
